// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      IDLE,
      WAIT
   } ifetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory read bus: request/address held until the memory acknowledges.
interface ifetch_if;
   import ifetch_pkg::*;

   logic               req;
   logic [ADDR_W-1:0]  addr;
   logic               ack;
   logic [INSTR_W-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries; flush beats push and pop.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     din,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A full buffer may still accept a push when the head leaves in the same cycle.
   assign do_push = push && ((count < CNT_W'(DEPTH)) || pop);
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr + 1'b1) & PTR_MASK;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches words over imem, presents one instruction per cycle.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched/perf_dropped/perf_stall_cycles counters.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   ifetch_if.master           imem,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [INSTR_W-1:0] ibus,
   output logic               ibus_valid,
   output logic [ADDR_W-1:0]  ibus_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_dropped,
   output logic [31:0]        perf_stall_cycles
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   ifetch_state_t     state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr_q;
   logic              drop;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      head;
   fetch_entry_t      din;
   logic              issue;
   logic              ack_seen;
   logic              push;
   logic              pop;

   // In IDLE nothing is outstanding, so the queue count alone is the occupancy.
   assign issue     = (state == IDLE) && (count < CNT_W'(DEPTH)) && !redirect;
   assign imem.req  = !reset && ((state == WAIT) || issue);
   assign imem.addr = (state == WAIT) ? addr_q : pc;
   assign ack_seen  = imem.req && imem.ack;

   assign push       = ack_seen && !drop && !redirect;
   assign ibus_valid = (count != '0);
   assign pop        = ibus_valid && !stall && !redirect;
   assign din        = '{pc: pc, instr: imem.rdata};

   assign ibus    = ibus_valid ? head.instr : NOP_INSTR;
   assign ibus_pc = ibus_valid ? head.pc : '0;

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (din),
      .count (count),
      .head  (head)
   );

   // A redirect that catches a request still in flight marks its word for discard;
   // the held request completes before fetch restarts at the new pc.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         addr_q <= RESET_PC;
         drop   <= 1'b0;
      end else begin
         if (ack_seen) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (push) begin
               pc <= pc + 32'd4;
            end
         end else if (issue) begin
            state  <= WAIT;
            addr_q <= pc;
         end
         if (redirect) begin
            pc <= align_word(redirect_pc);
            if ((state == WAIT) && !ack_seen) begin
               drop <= 1'b1;
            end
         end
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched      <= '0;
         perf_dropped      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         perf_fetched      <= perf_fetched + 32'(push);
         perf_dropped      <= perf_dropped + 32'(ack_seen && !push);
         perf_stall_cycles <= perf_stall_cycles + 32'(stall && ibus_valid);
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed handshake/redirect cases plus a randomized
// run against an instruction-stream reference model.
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] ibus;
   logic        ibus_valid;
   logic [31:0] ibus_pc;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
   logic [31:0] perf_stall_cycles;
`endif

   ifetch_if imem_bus();

   ifetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (imem_bus),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ibus        (ibus),
      .ibus_valid  (ibus_valid),
      .ibus_pc     (ibus_pc)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetched      (perf_fetched),
      .perf_dropped      (perf_dropped),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: acknowledges after a fixed or random number of wait states.
   int wcnt      = 0;
   int wlat      = 0;
   int fixed_lat = 0;
   bit rand_lat  = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return rand_lat ? (a ^ 32'h5A5A_A5A5) : a;
   endfunction

   assign imem_bus.ack   = imem_bus.req && (wcnt >= (rand_lat ? wlat : fixed_lat));
   assign imem_bus.rdata = mem_word(imem_bus.addr);

   always @(posedge clk) begin
      if (reset) begin
         wcnt <= 0;
      end else if (imem_bus.req && imem_bus.ack) begin
         wcnt <= 0;
         wlat <= $urandom_range(0, 3);
      end else if (imem_bus.req) begin
         wcnt <= wcnt + 1;
      end
   end

   int total = 0;
   int bad   = 0;

   // Reference: the pc the decode stage must see next, plus handshake history.
   logic [31:0] exp_pc;
   bit          prev_valid;
   bit          prev_consumed;
   bit          prev_req;
   bit          prev_ack;
   logic [31:0] prev_addr;
   int          dark_run;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_pc        = RESET_PC;
      prev_valid    = 1'b0;
      prev_consumed = 1'b0;
      prev_req      = 1'b0;
      prev_ack      = 1'b0;
      prev_addr     = '0;
      dark_run      = 0;
   endtask

   task automatic check_cycle();
      if (ibus_valid) begin
         check_output("head_pc", ibus_pc, exp_pc);
         check_output("head_instr", ibus, mem_word(exp_pc));
         dark_run = 0;
      end else begin
         check_output("nop_instr", ibus, NOP_INSTR);
         check_output("nop_pc", ibus_pc, 32'h0);
         dark_run++;
      end
      if (prev_valid && !prev_consumed) check_output("valid_hold", 32'(ibus_valid), 32'd1);
      if (prev_req && !prev_ack) begin
         check_output("req_hold", 32'(imem_bus.req), 32'd1);
         check_output("addr_hold", imem_bus.addr, prev_addr);
      end
      if (imem_bus.req) check_output("addr_align", 32'(imem_bus.addr[1:0]), 32'd0);
      if (dark_run > 16) begin
         check_output("progress", dark_run, 32'd16);
         dark_run = 0;
      end
      prev_valid    = ibus_valid;
      prev_consumed = redirect || (ibus_valid && !stall);
      prev_req      = imem_bus.req;
      prev_ack      = imem_bus.ack;
      prev_addr     = imem_bus.addr;
      if (redirect) begin
         exp_pc   = redirect_pc & ~32'h3;
         dark_run = 0;
      end else if (ibus_valid && !stall) begin
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic apply_stimulus(input bit s, input bit r, input logic [31:0] rpc);
      @(negedge clk);
      reset       = 1'b0;
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
      #1;
      check_cycle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      @(posedge clk);
      #1;
      check_output("rst_req", 32'(imem_bus.req), 32'd0);
      check_output("rst_addr", imem_bus.addr, RESET_PC);
      check_output("rst_ibus", ibus, 32'h0);
      check_output("rst_valid", 32'(ibus_valid), 32'd0);
      check_output("rst_ibus_pc", ibus_pc, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
      check_output("rst_perf_fetched", perf_fetched, 32'h0);
      check_output("rst_perf_dropped", perf_dropped, 32'h0);
      check_output("rst_perf_stall", perf_stall_cycles, 32'h0);
`endif
      model_reset();
   endtask

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      model_reset();

      // Zero-wait streaming from RESET_PC.
      do_reset();
      apply_stimulus(0, 0, 0);
      check_output("t1_req0", 32'(imem_bus.req), 32'd1);
      check_output("t1_addr0", imem_bus.addr, 32'h100);
      check_output("t1_valid0", 32'(ibus_valid), 32'd0);
      apply_stimulus(0, 0, 0);
      check_output("t1_addr1", imem_bus.addr, 32'h104);
      check_output("t1_ibus1", ibus, 32'h100);
      apply_stimulus(0, 0, 0);
      check_output("t1_addr2", imem_bus.addr, 32'h108);
      check_output("t1_ibus2", ibus, 32'h104);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, 0, 0);
         check_output("t1_stream_valid", 32'(ibus_valid), 32'd1);
      end

      // Stall from the first valid word fills the queue and stops fetching.
      do_reset();
      apply_stimulus(0, 0, 0);
      apply_stimulus(1, 0, 0);
      check_output("t2_ibus_first", ibus, 32'h100);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 0, 0);
         check_output("t2_req_off", 32'(imem_bus.req), 32'd0);
         check_output("t2_ibus_held", ibus, 32'h100);
      end
      apply_stimulus(0, 0, 0);
      check_output("t2_release", ibus, 32'h100);
      apply_stimulus(0, 0, 0);
      check_output("t2_next", ibus, 32'h104);

      // Redirect while IDLE, unaligned target.
      apply_stimulus(0, 1, 32'h2003);
      check_output("t3_req_redirect", 32'(imem_bus.req), 32'd0);
      apply_stimulus(0, 0, 0);
      check_output("t3_bubble", 32'(ibus_valid), 32'd0);
      check_output("t3_addr", imem_bus.addr, 32'h2000);
      apply_stimulus(0, 0, 0);
      check_output("t3_ibus", ibus, 32'h2000);

      // PC wraps at the top of the address space.
      apply_stimulus(0, 1, 32'hFFFF_FFF9);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 0);
      check_output("t4_pc_f8", ibus_pc, 32'hFFFF_FFF8);
      apply_stimulus(0, 0, 0);
      check_output("t4_pc_fc", ibus_pc, 32'hFFFF_FFFC);
      apply_stimulus(0, 0, 0);
      check_output("t4_pc_wrap", ibus_pc, 32'h0);

      // Three wait states, redirect in the middle of the wait.
      fixed_lat = 3;
      do_reset();
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 1, 32'h400);
      check_output("t5_addr_held0", imem_bus.addr, 32'h100);
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(0, 0, 0);
         check_output("t5_req_held", 32'(imem_bus.req), 32'd1);
         check_output("t5_addr_held", imem_bus.addr, 32'h100);
         check_output("t5_no_valid", 32'(ibus_valid), 32'd0);
      end
      apply_stimulus(0, 0, 0);
      check_output("t5_new_addr", imem_bus.addr, 32'h400);
      check_output("t5_dropped", 32'(ibus_valid), 32'd0);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0);
      check_output("t5_target_valid", 32'(ibus_valid), 32'd1);
      check_output("t5_target_pc", ibus_pc, 32'h400);

      // Redirect coinciding with the acknowledge.
      do_reset();
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0);
      apply_stimulus(0, 1, 32'h3000);
      check_output("t6_addr_ack", imem_bus.addr, 32'h100);
      apply_stimulus(0, 0, 0);
      check_output("t6_new_addr", imem_bus.addr, 32'h3000);
      check_output("t6_new_req", 32'(imem_bus.req), 32'd1);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0);
      check_output("t6_no_extra_drop", 32'(ibus_valid), 32'd1);
      check_output("t6_target_pc", ibus_pc, 32'h3000);

      // Reset while a request is outstanding with data buffered.
      fixed_lat = 0;
      do_reset();
      apply_stimulus(0, 0, 0);
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
      fixed_lat = 3;
      apply_stimulus(1, 0, 0);
      apply_stimulus(1, 0, 0);
      check_output("t7_wait_req", 32'(imem_bus.req), 32'd1);
      check_output("t7_wait_addr", imem_bus.addr, 32'h108);
      check_output("t7_ibus", ibus, 32'h104);
      do_reset();

      // Randomized latency, stalls and redirects.
      rand_lat = 1'b1;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit          s;
         bit          r;
         logic [31:0] t;
         s = ($urandom_range(0, 9) < 3);
         r = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         apply_stimulus(s, r, t);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
